// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// the UART starvation limit and the byte-assembly state encoding.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_PEND = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory write port between the CPU memory stage and a UART
// loader that assembles little-endian words from byte pairs and fills memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_neg,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              overflow
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  arb_state_e        state;
  logic [7:0]        low_byte;
  logic [DATA_W-1:0] pending_word;
  logic [ADDR_W-1:0] uart_addr;
  logic [CNT_W-1:0]  starve_cnt;
  logic              in_pend;
  logic              starved;
  logic              uart_grant;

  // The UART wins whenever the CPU is not writing, or once it has waited long
  // enough; in the latter case the CPU is held so its write is replayed later.
  assign in_pend    = (state == ST_PEND);
  assign starved    = (starve_cnt == STARVE_LIM);
  assign uart_grant = in_pend && (!cpu_we || starved);
  assign cpu_stall  = !reset && in_pend && cpu_we && starved;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (!reset) begin
      if (uart_grant) begin
        mem_we    = 1'b1;
        mem_addr  = uart_addr;
        mem_wdata = pending_word;
      end else begin
        mem_we = cpu_we;
      end
    end
  end

  // A byte arriving while a word is still waiting has nowhere to go, so it is
  // dropped and remembered in the sticky overflow flag.
  always_ff @(posedge clk_neg or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      low_byte     <= '0;
      pending_word <= '0;
      uart_addr    <= '0;
      starve_cnt   <= '0;
      overflow     <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      load_done <= uart_grant && (uart_addr == LAST_ADDR);
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            low_byte <= rx_byte;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (rx_valid) begin
            pending_word <= DATA_W'({rx_byte, low_byte});
            state        <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (uart_grant) begin
            uart_addr  <= uart_addr + ADDR_W'(1);
            starve_cnt <= '0;
            if (rx_valid) begin
              low_byte <= rx_byte;
              state    <= ST_LOW;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            if (!starved) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (rx_valid) begin
              overflow <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 16, data-memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the number of blocked UART cycles before the CPU is stalled.
REQ-004 SHALL have port clk_neg, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cpu_we, input, 1, memory-stage write request.
REQ-007 SHALL have port cpu_addr, input, ADDR_W, memory-stage address.
REQ-008 SHALL have port cpu_wdata, input, DATA_W, memory-stage write data.
REQ-009 SHALL have port rx_byte, input, 8, received UART byte.
REQ-010 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_byte.
REQ-011 SHALL have port mem_we, output, 1, data-memory write enable.
REQ-012 SHALL have port mem_addr, output, ADDR_W, data-memory address (read and write).
REQ-013 SHALL have port mem_wdata, output, DATA_W, data-memory write data.
REQ-014 SHALL have port cpu_stall, output, 1, holds the CPU pipeline for this cycle.
REQ-015 SHALL have port load_done, output, 1, one-cycle pulse after the UART word at address 2^ADDR_W-1 is written.
REQ-016 SHALL have port overflow, output, 1, sticky flag set when a UART byte is dropped.

Function
REQ-017 SHALL implement a byte-assembly FSM with states IDLE, LOW, PEND.
REQ-018 In IDLE, rx_valid SHALL latch rx_byte as the low byte and move the FSM to LOW.
REQ-019 In LOW, rx_valid SHALL form word {rx_byte, low byte}, little-endian, in the pending register and move the FSM to PEND.
REQ-020 uart_grant SHALL be asserted combinationally when state==PEND and (cpu_we==0 or starve_cnt==STARVE_MAX).
REQ-021 cpu_stall SHALL be asserted combinationally when state==PEND, cpu_we==1 and starve_cnt==STARVE_MAX; otherwise it SHALL be 0.
REQ-022 While uart_grant==1, the block SHALL drive mem_we=1, mem_addr=uart_addr and mem_wdata=pending word, and SHALL suppress the CPU write.
REQ-023 While uart_grant==0, the block SHALL drive mem_we=cpu_we, mem_addr=cpu_addr and mem_wdata=cpu_wdata.
REQ-024 On grant, uart_addr SHALL increment modulo 2^ADDR_W, wrapping 15->0, starve_cnt SHALL clear, and the FSM SHALL go to IDLE.
REQ-025 If rx_valid coincides with a grant, the byte SHALL be latched as the low byte and the FSM SHALL go to LOW instead of IDLE.
REQ-026 In PEND without a grant, starve_cnt SHALL increment, saturating at STARVE_MAX.
REQ-027 In PEND without a grant, rx_valid SHALL drop the byte and set overflow; overflow SHALL clear only on reset.
REQ-028 load_done SHALL pulse high for exactly the cycle after a grant that wrote address 2^ADDR_W-1.
REQ-029 Write latency from the second byte's rx_valid to mem_we SHALL be 1 cycle when the CPU is idle and at most STARVE_MAX+1 cycles otherwise.
REQ-030 The CPU read path SHALL be unaffected except during grant cycles, when cpu_stall or cpu_we==0 guarantees no CPU access is lost.

Reset
REQ-031 Reset SHALL asynchronously force state=IDLE, uart_addr=0, starve_cnt=0, low byte=0, pending word=0, overflow=0 and load_done=0.
REQ-032 While reset is high, mem_we=0 and cpu_stall=0 SHALL hold.
REQ-033 Reset asserted mid-word SHALL discard any partial or pending word, with no memory write.

Structure
REQ-034 The FSM state enum, the ADDR_W/DATA_W defaults and STARVE_MAX SHALL reside in shared package mem_arb_pkg.
REQ-035 The design SHALL be a single flat module; no sub-module is required.

Verification
REQ-036 Bytes 0x34 then 0x12 with cpu_we=0 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x1234, uart_addr becomes 1.
REQ-037 Word pending, cpu_we held at 1 -> uart_grant blocked for 4 cycles, 5th cycle cpu_stall=1 and the UART word is written.
REQ-038 32 bytes streamed with cpu_we=0 -> addresses 0..15 written in order, load_done pulses once, next word goes to address 0.
REQ-039 Byte arriving in PEND while cpu_we=1 and starve_cnt<4 -> byte dropped, overflow=1 and remains 1 until reset.
REQ-040 Byte arriving on a grant cycle -> word written and FSM in LOW holding the new byte.
REQ-041 Reset asserted in LOW and in PEND -> no mem_we, state IDLE, uart_addr=0 and overflow=0 after release.
